// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM/WB pipeline register with per-lane write qualification
// Optional feature macro: MEM_WB_PERF_CNT_EN (adds the retire_cnt output).
module mem_wb_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int LANES   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           valid_in,
  input  logic [LANES*DATA_W-1:0]    mem_in,
  input  logic [LANES*DATA_W-1:0]    B_in,
  input  logic [LANES*RADDR_W-1:0]   regWrAddr_in,
  input  logic [LANES-1:0]           MemtoReg_in,
  input  logic [LANES-1:0]           RegWr_in,
  output logic [LANES-1:0]           valid_out,
  output logic [LANES*DATA_W-1:0]    mem_out,
  output logic [LANES*DATA_W-1:0]    B_out,
  output logic [LANES*RADDR_W-1:0]   regWrAddr_out,
  output logic [LANES-1:0]           MemtoReg_out,
  output logic [LANES-1:0]           RegWr_out,
  output logic [LANES*DATA_W-1:0]    wb_data_out
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]                retire_cnt
`endif
);

  logic [LANES-1:0] squash;
  logic [LANES-1:0] reg_wr_next;

  // Squash an older lane when a younger valid lane writes the same nonzero register.
  always_comb begin
    squash = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (valid_in[j] && RegWr_in[j] &&
            (regWrAddr_in[j*RADDR_W +: RADDR_W] == regWrAddr_in[i*RADDR_W +: RADDR_W]) &&
            (regWrAddr_in[i*RADDR_W +: RADDR_W] != '0)) begin
          squash[i] = 1'b1;
        end
      end
    end
  end

  // Write enable only for valid, non-$zero, non-squashed lanes.
  always_comb begin
    reg_wr_next = '0;
    for (int i = 0; i < LANES; i++) begin
      reg_wr_next[i] = RegWr_in[i] && valid_in[i] &&
                       (regWrAddr_in[i*RADDR_W +: RADDR_W] != '0) && !squash[i];
    end
  end

  // Stage registers: reset and flush clear, stall holds, otherwise load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= '0;
      mem_out       <= '0;
      B_out         <= '0;
      regWrAddr_out <= '0;
      MemtoReg_out  <= '0;
      RegWr_out     <= '0;
    end else if (flush) begin
      valid_out     <= '0;
      mem_out       <= '0;
      B_out         <= '0;
      regWrAddr_out <= '0;
      MemtoReg_out  <= '0;
      RegWr_out     <= '0;
    end else if (!stall) begin
      valid_out     <= valid_in;
      mem_out       <= mem_in;
      B_out         <= B_in;
      regWrAddr_out <= regWrAddr_in;
      MemtoReg_out  <= MemtoReg_in;
      RegWr_out     <= reg_wr_next;
    end
  end

  // Writeback mux straight off the stage registers.
  always_comb begin
    wb_data_out = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_data_out[i*DATA_W +: DATA_W] = MemtoReg_out[i] ? mem_out[i*DATA_W +: DATA_W]
                                                        : B_out[i*DATA_W +: DATA_W];
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] valid_pop;

  // Number of valid lanes presented this cycle.
  always_comb begin
    valid_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      valid_pop = valid_pop + 32'(valid_in[i]);
    end
  end

  // Retired-instruction counter advances only on load edges; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (!flush && !stall) begin
      retire_cnt <= retire_cnt + valid_pop;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb/tb_mem_wb_pipe_reg.sv - self-checking bench for mem_wb_pipe_reg (LANES=2)
module tb_mem_wb_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  valid_in;
  logic [63:0] mem_in;
  logic [63:0] B_in;
  logic [9:0]  regWrAddr_in;
  logic [1:0]  MemtoReg_in;
  logic [1:0]  RegWr_in;
  logic [1:0]  valid_out;
  logic [63:0] mem_out;
  logic [63:0] B_out;
  logic [9:0]  regWrAddr_out;
  logic [1:0]  MemtoReg_out;
  logic [1:0]  RegWr_out;
  logic [63:0] wb_data_out;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mem_wb_pipe_reg #(.DATA_W(32), .RADDR_W(5), .LANES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .valid_in      (valid_in),
    .mem_in        (mem_in),
    .B_in          (B_in),
    .regWrAddr_in  (regWrAddr_in),
    .MemtoReg_in   (MemtoReg_in),
    .RegWr_in      (RegWr_in),
    .valid_out     (valid_out),
    .mem_out       (mem_out),
    .B_out         (B_out),
    .regWrAddr_out (regWrAddr_out),
    .MemtoReg_out  (MemtoReg_out),
    .RegWr_out     (RegWr_out),
    .wb_data_out   (wb_data_out)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .retire_cnt    (retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference stage contents
  logic [1:0]  m_valid;
  logic [63:0] m_mem;
  logic [63:0] m_b;
  logic [9:0]  m_addr;
  logic [1:0]  m_mtr;
  logic [1:0]  m_rw;
  logic [31:0] m_cnt;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] mem;
    logic [63:0] b;
    logic [9:0]  addr;
    logic [1:0]  mtr;
    logic [1:0]  rw;
    logic [1:0]  exp_rw;
    logic [63:0] exp_wb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Youngest-writer-wins rule for a two-lane bundle.
  function automatic logic [1:0] qual_rw(input logic [1:0] v, input logic [1:0] w,
                                         input logic [9:0] a);
    logic [4:0] a0, a1;
    logic [1:0] r;
    a0 = a[4:0];
    a1 = a[9:5];
    r[1] = v[1] & w[1] & (a1 != 0);
    r[0] = v[0] & w[0] & (a0 != 0) & !(v[1] & w[1] & (a1 == a0));
    return r;
  endfunction

  function automatic int popc(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic model_clear();
    m_valid = '0; m_mem = '0; m_b = '0; m_addr = '0; m_mtr = '0; m_rw = '0;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] exp_wb;
    for (int l = 0; l < 2; l++)
      exp_wb[l*32 +: 32] = m_mtr[l] ? m_mem[l*32 +: 32] : m_b[l*32 +: 32];
    chk({tag, ".valid_out"},     64'(valid_out),     64'(m_valid));
    chk({tag, ".mem_out"},       mem_out,            m_mem);
    chk({tag, ".B_out"},         B_out,              m_b);
    chk({tag, ".regWrAddr_out"}, 64'(regWrAddr_out), 64'(m_addr));
    chk({tag, ".MemtoReg_out"},  64'(MemtoReg_out),  64'(m_mtr));
    chk({tag, ".RegWr_out"},     64'(RegWr_out),     64'(m_rw));
    chk({tag, ".wb_data_out"},   wb_data_out,        exp_wb);
`ifdef MEM_WB_PERF_CNT_EN
    chk({tag, ".retire_cnt"},    64'(retire_cnt),    64'(m_cnt));
`endif
  endtask

  // Advance the model by the rules for the current inputs, then cross one edge.
  task automatic step();
    if (flush) begin
      model_clear();
    end else if (!stall) begin
      m_valid = valid_in;
      m_mem   = mem_in;
      m_b     = B_in;
      m_addr  = regWrAddr_in;
      m_mtr   = MemtoReg_in;
      m_rw    = qual_rw(valid_in, RegWr_in, regWrAddr_in);
      m_cnt   = m_cnt + 32'(popc(valid_in));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    valid_in = v.valid; mem_in = v.mem; B_in = v.b;
    regWrAddr_in = v.addr; MemtoReg_in = v.mtr; RegWr_in = v.rw;
  endtask

  initial begin
    vecs[0] = '{2'b01, 64'h00000000_AAAA0000, 64'h00000000_00000011, 10'h003, 2'b01, 2'b01,
                2'b01, 64'h00000000_AAAA0000};
    vecs[1] = '{2'b11, 64'h22222222_11111111, 64'h44444444_33333333, 10'h0E7, 2'b10, 2'b11,
                2'b10, 64'h22222222_33333333};
    vecs[2] = '{2'b01, 64'h22222222_11111111, 64'h44444444_33333333, 10'h0E7, 2'b10, 2'b11,
                2'b01, 64'h22222222_33333333};
    vecs[3] = '{2'b01, 64'h00000000_55555555, 64'h00000000_00000077, 10'h000, 2'b00, 2'b01,
                2'b00, 64'h00000000_00000077};
    vecs[4] = '{2'b11, 64'hDEADBEEF_CAFEF00D, 64'h00000000_00000000, 10'h124, 2'b11, 2'b11,
                2'b11, 64'hDEADBEEF_CAFEF00D};
    vecs[5] = '{2'b11, 64'h00000000_00000000, 64'h12345678_9ABCDEF0, 10'h0A5, 2'b00, 2'b01,
                2'b01, 64'h12345678_9ABCDEF0};
    vecs[6] = '{2'b10, 64'h00000000_00000000, 64'h12345678_9ABCDEF0, 10'h0A5, 2'b00, 2'b11,
                2'b10, 64'h12345678_9ABCDEF0};

    // reset state
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    valid_in = '0; mem_in = '0; B_in = '0; regWrAddr_in = '0; MemtoReg_in = '0; RegWr_in = '0;
    model_clear();
    m_cnt = '0;
    #1;
    check_all("reset");
    #1 rst_n = 1'b1;

    // table-driven single loads
    foreach (vecs[k]) begin
      apply_vec(vecs[k]);
      step();
      chk($sformatf("vec%0d.RegWr_out", k),   64'(RegWr_out), 64'(vecs[k].exp_rw));
      chk($sformatf("vec%0d.wb_data_out", k), wb_data_out,    vecs[k].exp_wb);
      chk($sformatf("vec%0d.valid_out", k),   64'(valid_out), 64'(vecs[k].valid));
      chk($sformatf("vec%0d.mem_out", k),     mem_out,        vecs[k].mem);
    end

    // asynchronous reset between edges with nonzero inputs
    apply_vec(vecs[4]);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    m_cnt = '0;
    check_all("async_reset");
    #1 rst_n = 1'b1;

    // load, hold through a 3-cycle stall, then stall+flush clears
    apply_vec(vecs[4]);
    step();
    stall = 1'b1;
    apply_vec(vecs[5]);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d.wb_data_out", c), wb_data_out,    vecs[4].exp_wb);
      chk($sformatf("stall%0d.RegWr_out", c),   64'(RegWr_out), 64'(vecs[4].exp_rw));
      check_all("stall");
    end
    flush = 1'b1;
    step();
    chk("stall_flush.valid_out", 64'(valid_out), 64'h0);
    chk("stall_flush.RegWr_out", 64'(RegWr_out), 64'h0);
    check_all("stall_flush");
    stall = 1'b0; flush = 1'b0;

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      valid_in     = 2'($urandom);
      RegWr_in     = 2'($urandom);
      MemtoReg_in  = 2'($urandom);
      mem_in       = {$urandom, $urandom};
      B_in         = {$urandom, $urandom};
      regWrAddr_in = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      step();
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath word width.
REQ-002 The block SHALL have parameter RADDR_W, default 5, giving the register-file write-address width.
REQ-003 The block SHALL have parameter LANES, default 2, giving the issue width; lane 0 is the oldest instruction in a bundle.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port stall, input, 1: hold all stage contents.
REQ-007 Port flush, input, 1: replace stage contents with a bubble.
REQ-008 Port valid_in, input, LANES: per-lane instruction-valid flag.
REQ-009 Port mem_in, input, LANES*DATA_W: per-lane memory read data; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port B_in, input, LANES*DATA_W: per-lane ALU/B result, packed as mem_in.
REQ-011 Port regWrAddr_in, input, LANES*RADDR_W: per-lane destination register, packed likewise.
REQ-012 Ports MemtoReg_in and RegWr_in, input, LANES each: per-lane writeback control.
REQ-013 Ports valid_out, mem_out, B_out, regWrAddr_out, MemtoReg_out and RegWr_out, output, widths matching the inputs: registered stage contents.
REQ-014 Port wb_data_out, output, LANES*DATA_W: per-lane writeback data, mem_out when MemtoReg_out is set, otherwise B_out.

Function
REQ-015 Load: when flush=0 and stall=0, every output register SHALL capture its input on the rising edge, giving a latency of exactly 1 cycle.
REQ-016 Hold: when stall=1 and flush=0, every output register SHALL keep its value.
REQ-017 Flush: when flush=1, valid_out, RegWr_out, MemtoReg_out, mem_out, B_out and regWrAddr_out SHALL all become 0 on the next edge; flush beats stall.
REQ-018 Qualified write: the captured RegWr_out[i] SHALL equal RegWr_in[i] AND valid_in[i] AND (regWrAddr_in lane i != 0) AND NOT squash[i].
REQ-019 Squash: squash[i] SHALL be 1 iff some lane j>i has valid_in[j]=1, RegWr_in[j]=1 and the same nonzero regWrAddr_in as lane i, so only the youngest writer to a register survives a bundle.
REQ-020 Squashed or invalid lanes SHALL still capture their data fields and valid_in; only RegWr_out is suppressed.
REQ-021 wb_data_out SHALL be purely combinational from the registered outputs, with no added latency.
REQ-022 With LANES=1 the squash logic SHALL reduce to constant 0.

Reset
REQ-023 While rst_n=0, every output register SHALL be 0 asynchronously, independent of clk.
REQ-024 Reset deassertion SHALL take effect only at clock edges; the first edge with rst_n=1 SHALL follow the REQ-015 to REQ-017 rules.
REQ-025 Reset asserted during a stall or flush SHALL override both.

Configuration
REQ-026 With macro MEM_WB_PERF_CNT_EN defined, the block SHALL have output retire_cnt, 32 bits, reset to 0.
REQ-027 With MEM_WB_PERF_CNT_EN, on each load edge (REQ-015) retire_cnt SHALL add popcount(valid_in), wrapping modulo 2^32; stall and flush edges SHALL not change it.
REQ-028 Without MEM_WB_PERF_CNT_EN, the retire_cnt port and its counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification (LANES=2, DATA_W=32, RADDR_W=5)
REQ-029 Reset: drive nonzero inputs, pulse rst_n low between clock edges -> all outputs read 0 immediately, before the next clk edge.
REQ-030 Load/mux: lane0 mem_in=0xAAAA0000, B_in=0x11, MemtoReg=1, RegWr=1, addr=3, valid=1 -> one edge later wb_data_out lane0=0xAAAA0000 and RegWr_out[0]=1.
REQ-031 Stall then flush: load a value, assert stall for 3 cycles -> outputs unchanged; assert stall=1 and flush=1 together -> valid_out=0 and RegWr_out=0 next edge.
REQ-032 Write-after-write: both lanes valid, RegWr=1, addr=7 -> RegWr_out=2'b10; with lane1 valid=0 instead -> RegWr_out=2'b01.
REQ-033 $zero: lane0 addr=0, RegWr=1, valid=1 -> RegWr_out[0]=0 while data is still captured.
REQ-034 Counter (macro defined): preset retire_cnt to 0xFFFFFFFF through 2^31-1 two-lane loads plus one single-lane load, then load with valid_in=2'b11 -> retire_cnt=0x00000001; with valid_in=2'b11 and stall=1 -> no change.
